registered_stream_mux: RTL and testbench

REGISTERED_STREAM_MUX -- requirements
Module: registered_stream_mux

---
 rtl/mux_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/registered_stream_mux.sv | 88 ++++++++
 tb/tb_registered_stream_mux.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the registered stream mux family.
package mux_pkg;

  localparam int MODE_SELECT = 0;
  localparam int MODE_RR     = 1;

  // Smallest r with 2**r >= n; usable in parameter expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << k) < n) r = k + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: first request at or above ptr wins, wrapping N_CH-1 -> 0.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int SW   = clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [SW-1:0]   ptr,
  output logic [N_CH-1:0] gnt,
  output logic [SW-1:0]   gnt_idx
);

  logic          found;
  logic [SW-1:0] idx;

  // N_CH is a power of two, so the SW-bit add wraps the search for free.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = ptr + SW'(k);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/registered_stream_mux.sv
// N-to-1 valid/ready stream mux with a single registered output stage;
// channel chosen by explicit select (MODE 0) or round-robin arbitration (MODE 1).
module registered_stream_mux
  import mux_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int WIDTH = 1,
  parameter  int MODE  = 0,
  localparam int SW    = clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*WIDTH-1:0] i,
  input  logic [N_CH-1:0]       i_valid,
  output logic [N_CH-1:0]       i_ready,
  input  logic [SW-1:0]         s,
  output logic [WIDTH-1:0]      out,
  output logic                  out_valid,
  output logic [SW-1:0]         out_ch,
  input  logic                  out_ready
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [SW-1:0]    out_ch_q, out_ch_d;
  logic [SW-1:0]    ptr_q, ptr_d;

  logic             load;
  logic [SW-1:0]    sel;
  logic [N_CH-1:0]  sel_oh;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;

  assign load = !out_valid_q || out_ready;

  generate
    if (MODE == MODE_RR) begin : g_rr
      rr_arbiter #(.N_CH(N_CH), .SW(SW)) u_arb (
        .req     (i_valid),
        .ptr     (ptr_q),
        .gnt     (sel_oh),
        .gnt_idx (sel)
      );
    end else begin : g_sel
      assign sel    = s;
      assign sel_oh = N_CH'(1) << s;
    end
  endgenerate

  // Gating with rst_n keeps ready low for the whole reset window, not just after the edge.
  assign i_ready  = (rst_n && load) ? sel_oh : '0;
  assign xfer     = |(i_valid & i_ready);
  assign sel_data = i[32'(sel)*WIDTH +: WIDTH];

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_d       = sel_data;
      out_ch_d    = sel;
      if (MODE == MODE_RR) ptr_d = sel + SW'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_registered_stream_mux.sv
// Directed and randomized scoreboard bench for registered_stream_mux across modes and sizes.
module tb_registered_stream_mux;

  logic clk, rst_n;
  int   checks, failures;

  // 4x8 explicit select
  logic [31:0] i0; logic [3:0] v0, r0; logic [1:0] s0, och0; logic [7:0] o0; logic ov0, ordy0;
  // 4x8 round-robin
  logic [31:0] i1; logic [3:0] v1, r1; logic [1:0] s1, och1; logic [7:0] o1; logic ov1, ordy1;
  // shared random stimulus for the sweep instances
  logic [511:0] wdat; logic [15:0] wvld; logic [3:0] ws; logic wrdy;
  logic [1:0]  rdy2; logic o2;        logic ov2; logic [0:0] och2;
  logic [15:0] rdy3; logic [31:0] o3; logic ov3; logic [3:0] och3;
  logic [15:0] rdy4; logic [31:0] o4; logic ov4; logic [3:0] och4;
  logic [1:0]  rdy5; logic o5;        logic ov5; logic [0:0] och5;

  registered_stream_mux #(.N_CH(4), .WIDTH(8), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .i(i0), .i_valid(v0), .i_ready(r0), .s(s0),
    .out(o0), .out_valid(ov0), .out_ch(och0), .out_ready(ordy0));
  registered_stream_mux #(.N_CH(4), .WIDTH(8), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i(i1), .i_valid(v1), .i_ready(r1), .s(s1),
    .out(o1), .out_valid(ov1), .out_ch(och1), .out_ready(ordy1));
  registered_stream_mux #(.N_CH(2), .WIDTH(1), .MODE(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .i(wdat[1:0]), .i_valid(wvld[1:0]), .i_ready(rdy2), .s(ws[0:0]),
    .out(o2), .out_valid(ov2), .out_ch(och2), .out_ready(wrdy));
  registered_stream_mux #(.N_CH(16), .WIDTH(32), .MODE(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .i(wdat), .i_valid(wvld), .i_ready(rdy3), .s(ws),
    .out(o3), .out_valid(ov3), .out_ch(och3), .out_ready(wrdy));
  registered_stream_mux #(.N_CH(16), .WIDTH(32), .MODE(0)) dut4 (
    .clk(clk), .rst_n(rst_n), .i(wdat), .i_valid(wvld), .i_ready(rdy4), .s(ws),
    .out(o4), .out_valid(ov4), .out_ch(och4), .out_ready(wrdy));
  registered_stream_mux #(.N_CH(2), .WIDTH(1), .MODE(0)) dut5 (
    .clk(clk), .rst_n(rst_n), .i(wdat[1:0]), .i_valid(wvld[1:0]), .i_ready(rdy5), .s(ws[0:0]),
    .out(o5), .out_valid(ov5), .out_ch(och5), .out_ready(wrdy));

  always #5 clk = ~clk;

  task automatic test_reset();
    #3;
    checks += 5;
    if (ov0 !== 1'b0) begin failures++; $display("FAIL reset_ov0: got %0b expected 0", ov0); end
    if (o0 !== 8'd0) begin failures++; $display("FAIL reset_out0: got %0h expected 0", o0); end
    if (och0 !== 2'd0) begin failures++; $display("FAIL reset_och0: got %0d expected 0", och0); end
    if (r0 !== 4'b0) begin failures++; $display("FAIL reset_rdy0: got %b expected 0000", r0); end
    if (ov1 !== 1'b0) begin failures++; $display("FAIL reset_ov1: got %0b expected 0", ov1); end
  endtask

  task automatic test_select();
    @(negedge clk);
    rst_n = 1'b1;
    i0 = {8'd44, 8'd33, 8'd22, 8'd11}; v0 = 4'hf; s0 = 2'd2; ordy0 = 1'b1;
    #1;
    checks++;
    if (r0 !== 4'b0100) begin failures++; $display("FAIL sel_ready: got %b expected 0100", r0); end
    @(posedge clk); #1;
    checks += 3;
    if (o0 !== 8'd33) begin failures++; $display("FAIL sel_out: got %0d expected 33", o0); end
    if (och0 !== 2'd2) begin failures++; $display("FAIL sel_ch: got %0d expected 2", och0); end
    if (ov0 !== 1'b1) begin failures++; $display("FAIL sel_valid: got %0b expected 1", ov0); end
  endtask

  task automatic test_backpressure();
    ordy0 = 1'b0; s0 = 2'd1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks += 3;
      if (o0 !== 8'd33) begin failures++; $display("FAIL bp_hold_out%0d: got %0d expected 33", k, o0); end
      if (ov0 !== 1'b1) begin failures++; $display("FAIL bp_hold_valid%0d: got %0b expected 1", k, ov0); end
      if (r0 !== 4'b0) begin failures++; $display("FAIL bp_ready%0d: got %b expected 0000", k, r0); end
      @(posedge clk); #1;
    end
    ordy0 = 1'b1;
    #1;
    checks++;
    if (r0 !== 4'b0010) begin failures++; $display("FAIL bp_release_ready: got %b expected 0010", r0); end
    @(posedge clk); #1;
    checks += 3;
    if (o0 !== 8'd22) begin failures++; $display("FAIL bp_reload_out: got %0d expected 22", o0); end
    if (och0 !== 2'd1) begin failures++; $display("FAIL bp_reload_ch: got %0d expected 1", och0); end
    if (ov0 !== 1'b1) begin failures++; $display("FAIL bp_reload_valid: got %0b expected 1", ov0); end
    v0 = 4'h0;
    @(posedge clk); #1;
    checks += 2;
    if (ov0 !== 1'b0) begin failures++; $display("FAIL drain_valid: got %0b expected 0", ov0); end
    if (o0 !== 8'd22) begin failures++; $display("FAIL drain_hold_out: got %0d expected 22", o0); end
  endtask

  task automatic test_rr_sequence();
    i1 = {8'hd3, 8'hc2, 8'hb1, 8'ha0}; v1 = 4'hf; ordy1 = 1'b1;
    #1;
    checks++;
    if (r1 !== 4'b0001) begin failures++; $display("FAIL rr_first_ready: got %b expected 0001", r1); end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks += 3;
      if (och1 !== 2'(k % 4)) begin failures++; $display("FAIL rr_seq_ch%0d: got %0d expected %0d", k, och1, k % 4); end
      if (o1 !== 8'(8'ha0 + (k % 4) * 8'h11)) begin failures++; $display("FAIL rr_seq_out%0d: got %0h", k, o1); end
      if (ov1 !== 1'b1) begin failures++; $display("FAIL rr_seq_valid%0d: got %0b expected 1", k, ov1); end
    end
  endtask

  task automatic test_rr_wrap_skip();
    v1 = 4'b0100;
    #1;
    checks++;
    if (r1 !== 4'b0100) begin failures++; $display("FAIL rr_skip_ready: got %b expected 0100", r1); end
    @(posedge clk); #1;
    checks++;
    if (och1 !== 2'd2) begin failures++; $display("FAIL rr_skip_ch: got %0d expected 2", och1); end
    v1 = 4'b0010;
    #1;
    checks++;
    if (r1 !== 4'b0010) begin failures++; $display("FAIL rr_wrap_ready: got %b expected 0010", r1); end
    @(posedge clk); #1;
    checks += 2;
    if (och1 !== 2'd1) begin failures++; $display("FAIL rr_wrap_ch: got %0d expected 1", och1); end
    if (o1 !== 8'hb1) begin failures++; $display("FAIL rr_wrap_out: got %0h expected b1", o1); end
    v1 = 4'b0;
    @(posedge clk); #1;
    checks += 2;
    if (ov1 !== 1'b0) begin failures++; $display("FAIL rr_idle_valid: got %0b expected 0", ov1); end
    if (och1 !== 2'd1) begin failures++; $display("FAIL rr_idle_hold_ch: got %0d expected 1", och1); end
    v1 = 4'hf;
    #1;
    checks++;
    if (r1 !== 4'b0100) begin failures++; $display("FAIL rr_ptr_kept_ready: got %b expected 0100", r1); end
    @(posedge clk); #1;
    checks += 2;
    if (och1 !== 2'd2) begin failures++; $display("FAIL rr_ptr_kept_ch: got %0d expected 2", och1); end
    if (ov1 !== 1'b1) begin failures++; $display("FAIL rr_ptr_kept_valid: got %0b expected 1", ov1); end
  endtask

  task automatic test_async_reset();
    #1;
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (ov1 !== 1'b0) begin failures++; $display("FAIL areset_valid: got %0b expected 0", ov1); end
    if (o1 !== 8'd0) begin failures++; $display("FAIL areset_out: got %0h expected 0", o1); end
    if (och1 !== 2'd0) begin failures++; $display("FAIL areset_ch: got %0d expected 0", och1); end
    if (r1 !== 4'b0) begin failures++; $display("FAIL areset_ready: got %b expected 0000", r1); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (r1 !== 4'b0001) begin failures++; $display("FAIL areset_first_ready: got %b expected 0001", r1); end
    @(posedge clk); #1;
    checks += 3;
    if (och1 !== 2'd0) begin failures++; $display("FAIL areset_first_ch: got %0d expected 0", och1); end
    if (ov1 !== 1'b1) begin failures++; $display("FAIL areset_first_valid: got %0b expected 1", ov1); end
    if (o1 !== 8'ha0) begin failures++; $display("FAIL areset_first_out: got %0h expected a0", o1); end
  endtask

  // Reference: output register holds at most one word; queue models it, ptr models RR priority.
  task automatic test_sweep(input int which, input int ncyc);
    int n, w, mode, ptr, g, c;
    int qch[$];
    logic [31:0] qd[$];
    logic [31:0] mask, act_o, d;
    logic [15:0] act_rdy, exp_rdy;
    logic [3:0]  act_ch;
    logic [511:0] tmp;
    logic act_ov, mv, ld, acc;
    case (which)
      2: begin n = 2;  w = 1;  mode = 1; end
      3: begin n = 16; w = 32; mode = 1; end
      4: begin n = 16; w = 32; mode = 0; end
      default: begin n = 2; w = 1; mode = 0; end
    endcase
    mask = (w >= 32) ? 32'hffff_ffff : (32'd1 << w) - 32'd1;
    @(negedge clk);
    wvld = '0; wrdy = 1'b0; rst_n = 1'b0;
    #2 rst_n = 1'b1;
    ptr = 0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 16; k++) wdat[k*32 +: 32] = $urandom;
      case ($urandom % 3)
        0: wvld = 16'($urandom);
        1: wvld = 16'($urandom & $urandom & $urandom);
        default: wvld = 16'hffff;
      endcase
      wrdy = ($urandom % 4) != 0;
      ws   = 4'($urandom);
      #1;
      mv = qd.size() != 0;
      ld = !mv || wrdy;
      g  = -1;
      if (mode == 0) g = int'(ws) % n;
      else for (int k = 0; k < n; k++) begin
        c = (ptr + k) % n;
        if (g < 0 && wvld[c]) g = c;
      end
      exp_rdy = (ld && g >= 0) ? 16'(1 << g) : 16'h0;
      acc = ld && g >= 0 && wvld[g];
      case (which)
        2: begin act_rdy = 16'(rdy2); act_o = 32'(o2); act_ov = ov2; act_ch = 4'(och2); end
        3: begin act_rdy = rdy3; act_o = o3; act_ov = ov3; act_ch = och3; end
        4: begin act_rdy = rdy4; act_o = o4; act_ov = ov4; act_ch = och4; end
        default: begin act_rdy = 16'(rdy5); act_o = 32'(o5); act_ov = ov5; act_ch = 4'(och5); end
      endcase
      checks += 2;
      if (act_rdy !== exp_rdy) begin failures++; $display("FAIL sweep%0d_ready cyc%0d: got %h expected %h", which, cyc, act_rdy, exp_rdy); end
      if (act_ov !== mv) begin failures++; $display("FAIL sweep%0d_valid cyc%0d: got %0b expected %0b", which, cyc, act_ov, mv); end
      if (mv) begin
        checks += 2;
        if (act_o !== qd[0]) begin failures++; $display("FAIL sweep%0d_data cyc%0d: got %h expected %h", which, cyc, act_o, qd[0]); end
        if (act_ch !== 4'(qch[0])) begin failures++; $display("FAIL sweep%0d_ch cyc%0d: got %0d expected %0d", which, cyc, act_ch, qch[0]); end
      end
      @(posedge clk);
      if (mv && wrdy) begin void'(qd.pop_front()); void'(qch.pop_front()); end
      if (acc) begin
        tmp = wdat >> (g * w);
        d   = tmp[31:0] & mask;
        qd.push_back(d);
        qch.push_back(g);
        if (mode == 1) ptr = (g + 1) % n;
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    clk = 1'b0; rst_n = 1'b0;
    i0 = '0; v0 = '0; s0 = '0; ordy0 = 1'b0;
    i1 = '0; v1 = '0; s1 = '0; ordy1 = 1'b0;
    wdat = '0; wvld = '0; ws = '0; wrdy = 1'b0;
    test_reset();
    test_select();
    test_backpressure();
    test_rr_sequence();
    test_rr_wrap_skip();
    test_async_reset();
    test_sweep(2, 400);
    test_sweep(3, 400);
    test_sweep(4, 400);
    test_sweep(5, 400);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
